// File: rtl/char_buffer_loader.sv
// Character buffer loader: fills a shadow buffer from data memory one byte at a
// time, then publishes the whole frame to char_data on a vsync falling edge so
// the renderer never sees a partially updated screen.
module char_buffer_loader #(
  parameter int unsigned N_CHARS    = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        auto_reload,
  input  logic        vsync,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  char_data [N_CHARS]
);

  localparam int unsigned IdxW = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CHARS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StWaitVs} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            vs_q;
  logic            done_q;
  logic [7:0]      shadow [N_CHARS];
  logic            vs_fall;
  logic            trig;

  assign vs_fall  = vs_q & ~vsync;
  assign trig     = start | (auto_reload & vs_fall);
  assign mem_req  = (state_q == StFetch);
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  // Address is a pure function of the registered index, so it holds while waiting.
  assign mem_addr = BASE_ADDR + 32'(idx_q);

  // Control FSM, vsync edge detector and the visible frame buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      vs_q    <= 1'b1;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(N_CHARS); i++) begin
        char_data[i] <= BLANK_CHAR;
      end
    end else begin
      vs_q   <= vsync;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (trig) begin
            idx_q   <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          if (mem_valid) begin
            if (idx_q == LastIdx) begin
              state_q <= StWaitVs;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StWaitVs: begin
          if (vs_fall) begin
            for (int i = 0; i < int'(N_CHARS); i++) begin
              char_data[i] <= shadow[i];
            end
            done_q <= 1'b1;
            // Auto mode commits and restarts the next fill on the same edge.
            if (auto_reload) begin
              idx_q   <= '0;
              state_q <= StFetch;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Shadow capture; no reset because it is only read after a complete fill.
  always_ff @(posedge clk) begin
    if ((state_q == StFetch) && mem_valid) begin
      shadow[idx_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_char_buffer_loader.sv
// Scoreboard bench for char_buffer_loader: expected request addresses and
// expected committed frames are queued by the stimulus and consumed by a monitor.
module tb_char_buffer_loader;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        auto_reload = 1'b0;
  logic        vsync = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic        busy;
  logic        done;
  logic [7:0]  char_data [N];

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] addr_q [$];
  int          frame_q [$];
  int          hs_cnt = 0;
  logic [7:0]  key = 8'h5A;
  int          wait_n = 0;
  int          wait_cnt = 0;
  int          nfill;
  int          base;

  always #5 clk = ~clk;

  char_buffer_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .auto_reload(auto_reload),
    .vsync      (vsync),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .busy       (busy),
    .done       (done),
    .char_data  (char_data)
  );

  // Memory model: data = addr[7:0] ^ key, wait_n wait cycles before each strobe.
  assign mem_valid = mem_req && (wait_cnt == wait_n);
  assign mem_rdata = mem_addr[7:0] ^ key;

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (mem_req && !mem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame code: -1 means all blank, otherwise entry i holds i ^ code.
  function automatic logic [7:0] exp_byte(input int f, input int i);
    return (f < 0) ? 8'h20 : (8'(i) ^ 8'(f));
  endfunction

  task automatic check_frame(input int f, input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++) begin
      if (bad < 0 && char_data[i] !== exp_byte(f, i)) bad = i;
    end
    if (bad < 0) check(1'b1, name, 0, 0);
    else check(1'b0, $sformatf("%s[%0d]", name, bad), 32'(char_data[bad]),
               32'(exp_byte(f, bad)));
  endtask

  task automatic push_load();
    for (int i = 0; i < N; i++) addr_q.push_back(32'h400 + 32'(i));
  endtask

  // Monitor: checks every request address and every committed frame.
  initial begin : monitor
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_req) begin
          if (addr_q.size() == 0) begin
            check(1'b0, "req_unexpected", mem_addr, 0);
          end else begin
            check(mem_addr === addr_q[0], "mem_addr", mem_addr, addr_q[0]);
            if (mem_valid) begin
              void'(addr_q.pop_front());
              hs_cnt++;
            end
          end
        end
        if (done) begin
          check(!done_prev, "done_width", 32'(done_prev), 0);
          if (frame_q.size() == 0) check(1'b0, "done_unexpected", 1, 0);
          else check_frame(frame_q.pop_front(), "commit_data");
        end
        done_prev = done;
      end else begin
        done_prev = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_fill(output int n);
    n = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (mem_req) n++;
      else break;
    end
    check(!mem_req, "fill_timeout", 32'(mem_req), 0);
  endtask

  task automatic wait_hs(input int target);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (hs_cnt >= target) break;
    end
    check(hs_cnt >= target, "hs_timeout", 32'(hs_cnt), 32'(target));
  endtask

  task automatic vs_pulse();
    @(posedge clk); #1 vsync = 1'b0;
    @(posedge clk); #1 vsync = 1'b1;
  endtask

  // Falling edge expected to commit frame f; the old frame must hold until E+1.
  task automatic vs_commit(input int f, input int old_f);
    frame_q.push_back(f);
    @(posedge clk); #1 vsync = 1'b0;
    @(negedge clk);
    check_frame(old_f, "frame_before_edge");
    check(!done, "done_early", 32'(done), 0);
    @(posedge clk); #1 vsync = 1'b1;
    @(negedge clk);
    check(done, "done_e1", 32'(done), 1);
    check_frame(f, "frame_e1");
  endtask

  initial begin
    // Reset state.
    cyc(3);
    check(!mem_req, "rst_mem_req", 32'(mem_req), 0);
    check(!busy, "rst_busy", 32'(busy), 0);
    check(!done, "rst_done", 32'(done), 0);
    check(mem_addr == 32'h400, "rst_mem_addr", mem_addr, 32'h400);
    check_frame(-1, "rst_frame");
    reset = 1'b1;
    cyc(2);
    check(!busy, "idle_busy", 32'(busy), 0);

    // Zero-wait fill.
    key = 8'h5A; wait_n = 0;
    push_load();
    pulse_start();
    wait_fill(nfill);
    check(nfill == 256, "fill_cycles_0ws", 32'(nfill), 256);
    check(addr_q.size() == 0, "req_count_0ws", 32'(addr_q.size()), 0);
    check(busy, "busy_wait_vs", 32'(busy), 1);
    cyc(4);
    vs_commit(8'h5A, -1);
    check(!busy, "busy_after_commit", 32'(busy), 0);

    // Three wait states per read.
    key = 8'hC3; wait_n = 3;
    push_load();
    pulse_start();
    wait_fill(nfill);
    check(nfill == 1024, "fill_cycles_3ws", 32'(nfill), 1024);
    vs_commit(8'hC3, 8'h5A);

    // Vsync edge in the middle of a fill is ignored.
    key = 8'h3C; wait_n = 1; base = hs_cnt;
    push_load();
    pulse_start();
    wait_hs(base + 100);
    vs_pulse();
    wait_fill(nfill);
    check(addr_q.size() == 0, "req_count_midedge", 32'(addr_q.size()), 0);
    check_frame(8'hC3, "no_commit_midedge");
    vs_commit(8'h3C, 8'hC3);

    // Auto mode: first edge loads, next edge commits and restarts.
    key = 8'h11; wait_n = 0; auto_reload = 1'b1;
    push_load();
    vs_pulse();
    wait_fill(nfill);
    check(nfill == 256, "fill_cycles_auto", 32'(nfill), 256);
    check_frame(8'h3C, "auto_no_commit_yet");
    key = 8'h77;
    push_load();
    vs_commit(8'h11, 8'h3C);
    check(mem_req, "auto_restart", 32'(mem_req), 1);
    wait_fill(nfill);
    auto_reload = 1'b0;
    vs_commit(8'h77, 8'h11);
    check(!busy, "auto_off_idle", 32'(busy), 0);

    // start and vsync edge together in IDLE yield one load.
    key = 8'h99; auto_reload = 1'b1;
    push_load();
    @(posedge clk); #1 start = 1'b1; vsync = 1'b0;
    @(posedge clk); #1 start = 1'b0; vsync = 1'b1;
    wait_fill(nfill);
    check(nfill == 256, "fill_cycles_dual", 32'(nfill), 256);
    auto_reload = 1'b0;
    cyc(3);
    check(addr_q.size() == 0, "single_load", 32'(addr_q.size()), 0);
    vs_commit(8'h99, 8'h77);

    // Reset in the middle of a fill.
    key = 8'hE1; base = hs_cnt;
    push_load();
    pulse_start();
    wait_hs(base + 128);
    #2 reset = 1'b0;
    #1;
    check(!mem_req, "midrst_mem_req", 32'(mem_req), 0);
    check(!busy, "midrst_busy", 32'(busy), 0);
    check(!done, "midrst_done", 32'(done), 0);
    check(mem_addr == 32'h400, "midrst_mem_addr", mem_addr, 32'h400);
    check_frame(-1, "midrst_frame");
    addr_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    cyc(3);
    check(!busy, "postrst_busy", 32'(busy), 0);
    key = 8'h4B;
    push_load();
    pulse_start();
    wait_fill(nfill);
    check(nfill == 256, "fill_cycles_postrst", 32'(nfill), 256);
    vs_commit(8'h4B, -1);

    cyc(5);
    check(addr_q.size() == 0, "addr_q_empty", 32'(addr_q.size()), 0);
    check(frame_q.size() == 0, "frame_q_empty", 32'(frame_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
